ifu: RTL and testbench
======================

// Module: ifu
// PURPOSE
//  Instruction fetch stage feeding IDU. Owns the PC and issues one word fetch at a time to the
//  instruction-memory port. Holds each returned instruction in a one-entry output register,
//  handed to decode with a valid/ready handshake. Applies redirects from EX/WB
//  (branch, jump, ecall, mret) and discards any wrong-path response still in flight.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC of the first fetch after reset
//  NOP_INST  32'h0000_0013  value driven on instD while outD_valid=0
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  ireq_valid     out  1   fetch request valid
//  ireq_ready     in   1   memory accepts request this cycle
//  ireq_addr      out  32  word address of the fetch (bits[1:0]=0)
//  iresp_valid    in   1   fetch data valid
//  iresp_ready    out  1   ifu accepts response this cycle
//  iresp_data     in   32  fetched instruction
//  outD_valid     out  1   instD/pcD hold a valid instruction
//  outD_ready     in   1   decode consumes the instruction this cycle
//  instD          out  32  instruction to IDU
//  pcD            out  32  PC of instD
//  opcodeD        out  7   instD[6:0]
//  funct3D        out  3   instD[14:12]
//  funct7D        out  7   instD[31:25]
//  funct12D       out  12  instD[31:20]
//  redirect_valid in   1   flush and restart fetch at redirect_pc
//  redirect_pc    in   32  new PC; bits[1:0] ignored (treated as 0)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - pc<=RESET_PC; state<=S_REQ; kill<=0; outD_valid<=0; instD<=NOP_INST; pcD<=0.
//  - ireq_valid=(state==S_REQ)&~rst, so there is no request while rst is high.
//  - Reset mid-transaction abandons it. The bench must not return the stale response.
//  FSM S_REQ:
//  - ireq_valid=1, ireq_addr=pc.
//  - On ireq_ready: req_pc<=pc, pc<=pc+4 (32-bit wrap), ->S_WAIT.
//  - The memory samples ireq_addr only on accept, so the address may change while ireq_ready=0.
//  FSM S_WAIT:
//  - ireq_valid=0, iresp_ready = kill | ~outD_valid | outD_ready.
//  - On response: if kill, drop the data and set kill<=0. Otherwise load the output register
//    (instD<=iresp_data, pcD<=req_pc, outD_valid<=1). In both cases ->S_REQ.
//  Output register:
//  - outD_valid && outD_ready with no refill in the same cycle -> outD_valid<=0, instD<=NOP_INST.
//  - Drain and refill in the same cycle -> the new instruction is valid next cycle (no bubble).
//  - instD/pcD stay stable while outD_valid=1 and outD_ready=0.
//  Redirect (highest priority, ignored during rst):
//  - pc<=redirect_pc&~3, outD_valid<=0, instD<=NOP_INST.
//  - S_REQ without accept: stay in S_REQ; next cycle ireq_addr=redirect target.
//  - S_REQ with accept the same cycle: ->S_WAIT with kill<=1 (wrong-path fetch is dropped).
//  - S_WAIT without response: kill<=1.
//  - S_WAIT with response the same cycle: the response is dropped, ->S_REQ, kill<=0.
//  - Redirect overrides outD_ready: an instruction handed over in that cycle is void.
//    Decode gates on redirect.
//  Latency: accept-to-outD_valid = memory latency + 1 cycle. Steady state is 1 instr per 2 cycles
//  plus memory latency (single outstanding request).
// STRUCTURE
//  - Shared package: state encodings (S_REQ, S_WAIT), RESET_PC, NOP_INST, shared with the pipeline
//    top-level and flush logic.
//  - One sub-module: ifu_out_reg (one-entry valid/ready holding register with flush input).
//  - FSM, pc, req_pc and kill live in ifu.
// TESTING
//  1. Reset, ireq_ready=1, 1-cycle memory -> first ireq_addr=80000000, then 80000004, 80000008.
//     pcD tracks these; instD=NOP while outD_valid=0.
//  2. Decode stall: outD_ready=0 for 5 cycles with a response pending -> iresp_ready=0.
//     instD/pcD stable. On release the next instruction appears without loss or duplication.
//  3. Redirect while in S_WAIT (response arrives 3 cycles later) to 80001000 -> stale data dropped.
//     Next valid pcD=80001000.
//  4. Redirect in the same cycle as an iresp handshake -> response dropped.
//     Next ireq_addr=redirect target; outD_valid=0 next cycle.
//  5. Redirect in the same cycle as an ireq accept -> that response is dropped. A second fetch at
//     the target follows. redirect_pc=80000102 gives ireq_addr=80000100.
//  6. Assert rst while in S_WAIT with outD_valid=1 -> next cycle outD_valid=0, instD=NOP,
//     ireq_valid=0. After release, ireq_addr=RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset PC and the
// NOP used to fill an empty decode slot.
package ifu_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } ifu_state_t;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_out_reg.sv
// One-entry valid/ready holding register between fetch and decode.
// Flush empties it; a load may coincide with a drain (no bubble).
module ifu_out_reg #(
    parameter logic [31:0] NOP_INST = ifu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage: owns the PC, keeps one fetch in flight and
// drops wrong-path responses after a redirect.
module ifu #(
    parameter logic [31:0] RESET_PC = ifu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = ifu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ireq_valid,
    input  logic        ireq_ready,
    output logic [31:0] ireq_addr,
    input  logic        iresp_valid,
    output logic        iresp_ready,
    input  logic [31:0] iresp_data,
    output logic        outD_valid,
    input  logic        outD_ready,
    output logic [31:0] instD,
    output logic [31:0] pcD,
    output logic [6:0]  opcodeD,
    output logic [2:0]  funct3D,
    output logic [6:0]  funct7D,
    output logic [11:0] funct12D,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    import ifu_pkg::*;

    ifu_state_t  r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_req_pc, w_req_pc_nxt;
    logic        r_kill, w_kill_nxt;
    logic        w_redir, w_acc, w_resp, w_load;

    assign w_redir     = redirect_valid & ~rst;
    assign ireq_valid  = (r_state == S_REQ) & ~rst;
    assign ireq_addr   = r_pc;
    assign iresp_ready = (r_state == S_WAIT)
                       & (r_kill | ~outD_valid | outD_ready);
    assign w_acc       = ireq_valid & ireq_ready;
    assign w_resp      = iresp_valid & iresp_ready;
    assign w_load      = w_resp & ~r_kill & ~w_redir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_kill   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_req_pc <= w_req_pc_nxt;
            r_kill   <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_req_pc_nxt = r_req_pc;
        w_kill_nxt   = r_kill;
        unique case (r_state)
            S_REQ: begin
                if (w_acc) begin
                    w_req_pc_nxt = r_pc;
                    w_pc_nxt     = r_pc + 32'd4;
                    w_state_nxt  = S_WAIT;
                    w_kill_nxt   = w_redir;
                end
            end
            S_WAIT: begin
                if (w_resp) begin
                    w_state_nxt = S_REQ;
                    w_kill_nxt  = 1'b0;
                end else if (w_redir) begin
                    w_kill_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
        // a redirect always wins over the sequential PC
        if (w_redir) begin
            w_pc_nxt = align_pc(redirect_pc);
        end
    end

    ifu_out_reg #(
        .NOP_INST (NOP_INST)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redir),
        .i_load  (w_load),
        .i_inst  (iresp_data),
        .i_pc    (r_req_pc),
        .i_ready (outD_ready),
        .o_valid (outD_valid),
        .o_inst  (instD),
        .o_pc    (pcD)
    );

    assign opcodeD  = instD[6:0];
    assign funct3D  = instD[14:12];
    assign funct7D  = instD[31:25];
    assign funct12D = instD[31:20];

endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu: memory model with variable latency, expected
// decode stream kept as a queue of PCs restarted on reset/redirect.
module tb_ifu;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid, ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid, iresp_ready;
    logic [31:0] iresp_data;
    logic        outD_valid, outD_ready;
    logic [31:0] instD, pcD;
    logic [6:0]  opcodeD;
    logic [2:0]  funct3D;
    logic [6:0]  funct7D;
    logic [11:0] funct12D;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .ireq_valid     (ireq_valid),
        .ireq_ready     (ireq_ready),
        .ireq_addr      (ireq_addr),
        .iresp_valid    (iresp_valid),
        .iresp_ready    (iresp_ready),
        .iresp_data     (iresp_data),
        .outD_valid     (outD_valid),
        .outD_ready     (outD_ready),
        .instD          (instD),
        .pcD            (pcD),
        .opcodeD        (opcodeD),
        .funct3D        (funct3D),
        .funct7D        (funct7D),
        .funct12D       (funct12D),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] fetch_exp;
    bit          mem_busy, mem_stale;
    logic [31:0] mem_addr;
    int          mem_lat;
    int          stall_cnt;
    bit          directed;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        for (int k = 0; k < 1024; k++)
            exp_q.push_back(pc + 32'(4 * k));
    endtask

    // driver + memory model
    initial begin
        rst = 1'b1; ireq_ready = 1'b0; iresp_valid = 1'b0;
        iresp_data = '0; outD_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        mem_busy = 1'b0; mem_stale = 1'b0; mem_addr = '0; mem_lat = 0;
        stall_cnt = 0; fetch_exp = RESET_PC;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            directed = (cyc < 40);
            rst = (cyc < 2) || (cyc > 50 && $urandom_range(0, 399) == 0);
            ireq_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (directed) begin
                outD_ready = 1'b1;
            end else if (stall_cnt > 0) begin
                outD_ready = 1'b0;
                stall_cnt--;
            end else if ($urandom_range(0, 49) == 0) begin
                outD_ready = 1'b0;
                stall_cnt = $urandom_range(4, 12);
            end else begin
                outD_ready = ($urandom_range(0, 9) < 7);
            end
            redirect_valid = !rst && !directed
                           && ($urandom_range(0, 11) == 0);
            redirect_pc = 32'h8000_0000 | ($urandom & 32'h0000_3FFF);
            iresp_valid = !rst && mem_busy && (mem_lat == 0);
            iresp_data = iresp_valid ? mem_word(mem_addr) : $urandom;
            #1;
            if (rst) begin
                chk("ireq_valid_in_reset", 32'(ireq_valid), 32'd0);
            end else begin
                chk("iresp_ready", 32'(iresp_ready),
                    32'(mem_busy && (mem_stale || !outD_valid
                                     || outD_ready)));
            end
            if (iresp_valid && iresp_ready) begin
                mem_busy = 1'b0;
                mem_stale = 1'b0;
            end else if (mem_busy) begin
                if (mem_lat > 0) mem_lat--;
                if (redirect_valid) mem_stale = 1'b1;
            end
            if (ireq_valid && ireq_ready) begin
                chk("accept_while_busy", 32'(mem_busy), 32'd0);
                chk("ireq_addr", ireq_addr, fetch_exp);
                mem_busy = 1'b1;
                mem_addr = ireq_addr;
                mem_lat = directed ? 0 : $urandom_range(0, 3);
                mem_stale = redirect_valid;
                fetch_exp = fetch_exp + 32'd4;
            end
            if (rst) begin
                mem_busy = 1'b0;
                mem_stale = 1'b0;
                fetch_exp = RESET_PC;
                restart(RESET_PC);
            end else if (redirect_valid) begin
                fetch_exp = redirect_pc & ~32'd3;
                restart(fetch_exp);
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    // monitor: pops the expected stream on each decode handshake
    bit          m_prev_rst = 1'b0;
    bit          m_prev_redir = 1'b0;
    bit          m_prev_hold = 1'b0;
    logic [31:0] m_prev_inst, m_prev_pc, m_pc, m_w;
    int          m_idle = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (m_prev_rst) begin
                chk("reset_outD_valid", 32'(outD_valid), 32'd0);
                chk("reset_instD", instD, NOP_INST);
                chk("reset_pcD", pcD, 32'd0);
            end else if (m_prev_redir) begin
                chk("valid_after_redirect", 32'(outD_valid), 32'd0);
            end
            if (m_prev_hold) begin
                chk("stall_instD_stable", instD, m_prev_inst);
                chk("stall_pcD_stable", pcD, m_prev_pc);
            end
            if (!outD_valid)
                chk("nop_when_invalid", instD, NOP_INST);
            if (!rst && !redirect_valid && outD_valid && outD_ready) begin
                m_idle = 0;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_instr: pcD %h with nothing expected",
                             pcD);
                end else begin
                    m_pc = exp_q.pop_front();
                    m_w = mem_word(m_pc);
                    chk("pcD", pcD, m_pc);
                    chk("instD", instD, m_w);
                    chk("opcodeD", 32'(opcodeD), 32'(m_w[6:0]));
                    chk("funct3D", 32'(funct3D), 32'(m_w[14:12]));
                    chk("funct7D", 32'(funct7D), 32'(m_w[31:25]));
                    chk("funct12D", 32'(funct12D), 32'(m_w[31:20]));
                end
            end else if (rst || redirect_valid) begin
                m_idle = 0;
            end else begin
                m_idle++;
            end
            if (m_idle > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL watchdog: %0d cycles without handover, need < 200",
                         m_idle);
                m_idle = 0;
            end
            m_prev_hold = !rst && !redirect_valid
                        && outD_valid && !outD_ready;
            m_prev_inst = instD;
            m_prev_pc = pcD;
            m_prev_rst = rst;
            m_prev_redir = redirect_valid;
        end
    end

endmodule
